// File: rtl/ctrl_seq.sv
`default_nettype none
// ============================================================================
// ctrl_seq : registered control-word sequencer with exception/interrupt entry
//            and NOP flush.                                       Rev 1.0
// ============================================================================
module ctrl_seq #(
    parameter int                     SIG_W     = 41,
    parameter int                     N_EXC     = 4,
    parameter int                     N_INT     = 3,
    parameter int                     FLUSH_CYC = 2,
    parameter logic [SIG_W-1:0]       RST_WORD  = '0,
    parameter logic [SIG_W-1:0]       BOOT_WORD = '0,
    parameter logic [SIG_W-1:0]       NOP_WORD  = '0,
    parameter logic [N_EXC*SIG_W-1:0] EXC_WORDS = '0,
    parameter logic [N_INT*SIG_W-1:0] INT_WORDS = '0,
    parameter int                     HAZ_LSB   = 24,
    parameter logic [7:0]             HAZ_VAL   = 8'b0100_0111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SIG_W-1:0] dec_word,
    input  logic             ctrl_haz,
    input  logic [N_EXC-1:0] exceptions,
    input  logic [N_INT-1:0] interrupts,
    input  logic             int_ret,
    output logic [SIG_W-1:0] signals,
    output logic [2:0]       state_o,
    output logic             int_busy
);

    localparam logic [2:0] S_BOOT  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_EXC   = 3'd2;
    localparam logic [2:0] S_INT   = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;
    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYC);

    logic [2:0]       state_q, state_d;
    logic [SIG_W-1:0] signals_q, signals_d;
    logic [N_INT-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic [3:0]       fcnt_q, fcnt_d;

    logic             exc_any;
    logic [SIG_W-1:0] exc_word;
    logic [N_INT-1:0] int_avail;
    logic [N_INT-1:0] int_sel;
    logic [SIG_W-1:0] int_word;
    logic [SIG_W-1:0] dec_haz;
    logic             int_take;
    logic             flush_last;

    // Descending scans so the lowest set index is the one that sticks.
    always_comb begin
        exc_any  = |exceptions;
        exc_word = NOP_WORD;
        for (int e = N_EXC - 1; e >= 0; e--) begin
            if (exceptions[e]) exc_word = EXC_WORDS[e*SIG_W +: SIG_W];
        end
    end

    always_comb begin
        int_avail = pend_q & ~{N_INT{busy_q}};
        int_sel   = '0;
        int_word  = NOP_WORD;
        for (int i = N_INT - 1; i >= 0; i--) begin
            if (int_avail[i]) begin
                int_sel  = '0;
                int_sel[i] = 1'b1;
                int_word = INT_WORDS[i*SIG_W +: SIG_W];
            end
        end
    end

    always_comb begin
        dec_haz = dec_word;
        if (ctrl_haz) dec_haz[HAZ_LSB +: 8] = HAZ_VAL;
    end

    assign flush_last = (fcnt_q <= 4'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_BOOT;
            signals_q <= RST_WORD;
            pend_q    <= '0;
            busy_q    <= 1'b0;
            fcnt_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            signals_q <= signals_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            fcnt_q    <= fcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        int_take = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (exc_any) begin
                    state_d = S_EXC;
                end else if (|int_avail) begin
                    state_d  = S_INT;
                    int_take = 1'b1;
                end
            end
            S_EXC, S_INT: begin
                state_d = S_FLUSH;
                fcnt_d  = FLUSH_LD;
            end
            S_FLUSH: begin
                if (flush_last) begin
                    state_d = S_RUN;
                    fcnt_d  = 4'd0;
                end else begin
                    fcnt_d  = fcnt_q - 4'd1;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    // The word loaded on the last FLUSH cycle is the first RUN-cycle word,
    // so exactly FLUSH_CYC NOPs follow an entry word.
    always_comb begin
        signals_d = NOP_WORD;
        case (state_q)
            S_BOOT:  signals_d = BOOT_WORD;
            S_RUN:   signals_d = exc_any ? exc_word : ((|int_avail) ? int_word : dec_haz);
            S_FLUSH: signals_d = flush_last ? dec_word : NOP_WORD;
            default: signals_d = NOP_WORD;
        endcase
        pend_d = (pend_q & ~(int_take ? int_sel : '0)) | interrupts;
        if (int_take)     busy_d = 1'b1;
        else if (int_ret) busy_d = 1'b0;
        else              busy_d = busy_q;
    end

    assign signals  = signals_q;
    assign state_o  = state_q;
    assign int_busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_seq.sv
`default_nettype none
// ============================================================================
// tb_ctrl_seq : directed bench for ctrl_seq (default and swept parameter sets)
//               against a behavioural model.                       Rev 1.0
// ============================================================================
module tb_ctrl_seq;

    localparam logic [40:0]   A_RST  = 41'h0AA_AAAA_0001;
    localparam logic [40:0]   A_BOOT = 41'h100_0000_0B00;
    localparam logic [40:0]   A_NOP  = 41'h000_0000_00F0;
    localparam logic [163:0]  A_EXC  = {41'h0E3_0000_0003, 41'h0E2_0000_0002,
                                        41'h0E1_0000_0001, 41'h0E0_0000_0000};
    localparam logic [122:0]  A_INT  = {41'h0C2_0000_0002, 41'h0C1_0000_0001,
                                        41'h0C0_0000_0000};
    localparam logic [63:0]   B_RST  = 64'hB0B0_0000_0000_0001;
    localparam logic [63:0]   B_BOOT = 64'hB007_0000_0000_0000;
    localparam logic [63:0]   B_NOP  = 64'h0000_0000_0000_00F0;
    localparam logic [511:0]  B_EXC  = {64'hEE00_0000_0000_0007, 64'hEE00_0000_0000_0006,
                                        64'hEE00_0000_0000_0005, 64'hEE00_0000_0000_0004,
                                        64'hEE00_0000_0000_0003, 64'hEE00_0000_0000_0002,
                                        64'hEE00_0000_0000_0001, 64'hEE00_0000_0000_0000};
    localparam logic [63:0]   B_INT  = 64'hCC00_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] dec = '0;
    logic        haz = 1'b0;
    logic [7:0]  exc = '0;
    logic [2:0]  intr = '0;
    logic        iret = 1'b0;

    logic [40:0] a_sig;
    logic [2:0]  a_st;
    logic        a_busy;
    logic [63:0] b_sig;
    logic [2:0]  b_st;
    logic        b_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ctrl_seq #(
        .SIG_W(41), .N_EXC(4), .N_INT(3), .FLUSH_CYC(2),
        .RST_WORD(A_RST), .BOOT_WORD(A_BOOT), .NOP_WORD(A_NOP),
        .EXC_WORDS(A_EXC), .INT_WORDS(A_INT)
    ) u_a (
        .clk(clk), .reset(rst_n), .dec_word(dec[40:0]), .ctrl_haz(haz),
        .exceptions(exc[3:0]), .interrupts(intr), .int_ret(iret),
        .signals(a_sig), .state_o(a_st), .int_busy(a_busy)
    );

    ctrl_seq #(
        .SIG_W(64), .N_EXC(8), .N_INT(1), .FLUSH_CYC(1),
        .RST_WORD(B_RST), .BOOT_WORD(B_BOOT), .NOP_WORD(B_NOP),
        .EXC_WORDS(B_EXC), .INT_WORDS(B_INT)
    ) u_b (
        .clk(clk), .reset(rst_n), .dec_word(dec), .ctrl_haz(haz),
        .exceptions(exc), .interrupts(intr[0:0]), .int_ret(iret),
        .signals(b_sig), .state_o(b_st), .int_busy(b_busy)
    );

    // ---------------- behavioural model (one slot per instance) ----------------
    int          cw[2] = '{41, 64};
    int          ce[2] = '{4, 8};
    int          ci[2] = '{3, 1};
    int          cf[2] = '{2, 1};
    logic [63:0] w_rst[2], w_boot[2], w_nop[2];
    logic [63:0] w_exc[2][8];
    logic [63:0] w_int[2][3];

    int          m_mode[2];   // 0 boot, 1 run, 2 exc, 3 int, 4 flush
    int          m_left[2];   // flush cycles still to run
    logic [63:0] m_sig[2];
    logic [7:0]  m_pend[2];
    logic        m_busy[2];

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset(input int k);
        m_mode[k] = 0; m_left[k] = 0; m_sig[k] = w_rst[k];
        m_pend[k] = '0; m_busy[k] = 1'b0;
    endtask

    task automatic model_step(input int k);
        logic [63:0] msk;
        logic [7:0]  ev, iv;
        int          e, i;
        logic        take;
        msk  = (cw[k] == 64) ? '1 : ((64'd1 << cw[k]) - 64'd1);
        ev   = exc & 8'((16'd1 << ce[k]) - 16'd1);
        iv   = {5'b0, intr} & 8'((16'd1 << ci[k]) - 16'd1);
        e    = lowest(ev);
        take = 1'b0;
        case (m_mode[k])
            0: begin m_sig[k] = w_boot[k]; m_mode[k] = 1; end
            1: begin
                i = lowest(m_busy[k] ? 8'h00 : m_pend[k]);
                if (e >= 0) begin
                    m_sig[k] = w_exc[k][e]; m_mode[k] = 2; m_left[k] = cf[k];
                end else if (i >= 0) begin
                    m_sig[k] = w_int[k][i]; m_pend[k][i] = 1'b0; take = 1'b1;
                    m_mode[k] = 3; m_left[k] = cf[k];
                end else begin
                    m_sig[k] = dec & msk;
                    if (haz) m_sig[k][31:24] = 8'h47;
                end
            end
            2, 3: begin m_sig[k] = w_nop[k]; m_mode[k] = 4; end
            default: begin
                if (m_left[k] == 1) begin m_sig[k] = dec & msk; m_mode[k] = 1; end
                else begin m_sig[k] = w_nop[k]; m_left[k] = m_left[k] - 1; end
            end
        endcase
        if (take)      m_busy[k] = 1'b1;
        else if (iret) m_busy[k] = 1'b0;
        m_pend[k] = m_pend[k] | iv;
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 8; j++) w_exc[k][j] = '0;
        w_rst[0] = 64'(A_RST); w_boot[0] = 64'(A_BOOT); w_nop[0] = 64'(A_NOP);
        w_rst[1] = B_RST;      w_boot[1] = B_BOOT;      w_nop[1] = B_NOP;
        for (int j = 0; j < 4; j++) w_exc[0][j] = 64'(A_EXC[j*41 +: 41]);
        for (int j = 0; j < 8; j++) w_exc[1][j] = B_EXC[j*64 +: 64];
        for (int j = 0; j < 3; j++) w_int[0][j] = 64'(A_INT[j*41 +: 41]);
        w_int[1][0] = B_INT; w_int[1][1] = '0; w_int[1][2] = '0;
        model_reset(0); model_reset(1);
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) model_reset(k);
                else        model_step(k);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("a.signals", 64'(a_sig), m_sig[0]);
            chk("a.state",   64'(a_st), 64'(m_mode[0]));
            chk("a.busy",    64'(a_busy), 64'(m_busy[0]));
            chk("b.signals", b_sig, m_sig[1]);
            chk("b.state",   64'(b_st), 64'(m_mode[1]));
            chk("b.busy",    64'(b_busy), 64'(m_busy[1]));
        end
    end

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    // exc[31:24] intr[23:21] haz[20] iret[19] dec[15:0]
    logic [31:0] vecs[15] = '{
        32'h00_4_0_1111, 32'h00_0_0_2222, 32'h08_0_0_3333, 32'h08_0_0_4444,
        32'h08_0_0_5555, 32'h08_0_0_6666, 32'h00_1_0_FFFF, 32'h00_1_8_AAAA,
        32'h00_1_0_0F0F, 32'h80_E_0_7777, 32'h00_0_0_1234, 32'h00_0_8_5678,
        32'h03_0_0_9999, 32'h00_0_0_BEEF, 32'h00_0_0_0000
    };

    initial begin
        tick(); tick();
        chk("lit.rst_sig",   64'(a_sig), 64'(A_RST));
        chk("lit.rst_state", 64'(a_st), 64'd0);
        chk("lit.rst_busy",  64'(a_busy), 64'd0);
        chk("lit.b_rst_sig", b_sig, B_RST);
        rst_n = 1'b1; dec = 64'h1A3;
        tick();                                             // T1
        chk("lit.boot_sig",   64'(a_sig), 64'(A_BOOT));
        chk("lit.boot_state", 64'(a_st), 64'd1);
        tick();                                             // T2
        chk("lit.dec_pass", 64'(a_sig), 64'h1A3);
        haz = 1'b1; dec = '0;
        tick();                                             // T3
        chk("lit.haz_a", 64'(a_sig), 64'h47_00_0000);
        chk("lit.haz_b", b_sig, 64'h47_00_0000);
        haz = 1'b0; dec = 64'h55; exc = 8'b0110; intr = 3'b001;
        tick();                                             // T4
        chk("lit.exc1_sig",   64'(a_sig), 64'h0E1_0000_0001);
        chk("lit.exc1_state", 64'(a_st), 64'd2);
        chk("lit.b_exc1",     b_sig, 64'hEE00_0000_0000_0001);
        exc = '0; intr = '0;
        tick();                                             // T5
        chk("lit.nop1",       64'(a_sig), 64'(A_NOP));
        chk("lit.nop1_state", 64'(a_st), 64'd4);
        chk("lit.b_nop",      b_sig, B_NOP);
        tick();                                             // T6
        chk("lit.nop2",       64'(a_sig), 64'(A_NOP));
        chk("lit.b_back_run", 64'(b_st), 64'd1);
        tick();                                             // T7
        chk("lit.back_run",   64'(a_sig), 64'h55);
        chk("lit.run_state",  64'(a_st), 64'd1);
        chk("lit.b_int0",     b_sig, B_INT);
        tick();                                             // T8
        chk("lit.int0_sig",   64'(a_sig), 64'h0C0_0000_0000);
        chk("lit.int0_state", 64'(a_st), 64'd3);
        chk("lit.int0_busy",  64'(a_busy), 64'd1);
        intr = 3'b101;
        tick(); intr = '0;                                  // T9
        tick(); tick();                                     // T11
        chk("lit.flush_done", 64'(a_st), 64'd1);
        tick();                                             // T12
        chk("lit.masked_sig",  64'(a_sig), 64'h55);
        chk("lit.masked_busy", 64'(a_busy), 64'd1);
        iret = 1'b1;
        tick();                                             // T13
        chk("lit.ret_clears", 64'(a_busy), 64'd0);
        tick();                                             // T14
        chk("lit.int0b_sig",     64'(a_sig), 64'h0C0_0000_0000);
        chk("lit.ret_coincide",  64'(a_busy), 64'd1);
        iret = 1'b0;
        tick(); tick(); tick(); tick();                     // T18
        chk("lit.int2_held_sig",  64'(a_sig), 64'h55);
        chk("lit.int2_held_busy", 64'(a_busy), 64'd1);
        iret = 1'b1;
        tick(); iret = 1'b0;                                // T19
        tick();                                             // T20
        chk("lit.int2_sig",   64'(a_sig), 64'h0C2_0000_0002);
        chk("lit.int2_state", 64'(a_st), 64'd3);
        tick(); intr = 3'b010;                              // T21
        tick(); intr = '0;                                  // T22
        chk("lit.flush2_state", 64'(a_st), 64'd4);
        rst_n = 1'b0;
        #1;
        chk("lit.abort_sig",   64'(a_sig), 64'(A_RST));
        chk("lit.abort_state", 64'(a_st), 64'd0);
        tick();                                             // T23
        rst_n = 1'b1;
        tick();                                             // T24
        chk("lit.reboot_sig", 64'(a_sig), 64'(A_BOOT));
        tick();                                             // T25
        chk("lit.no_pend_sig",   64'(a_sig), 64'h55);
        chk("lit.no_pend_state", 64'(a_st), 64'd1);
        foreach (vecs[v]) begin
            exc  = vecs[v][31:24];
            intr = vecs[v][23:21];
            haz  = vecs[v][20];
            iret = vecs[v][19];
            dec  = 64'(vecs[v][15:0]);
            tick();
        end
        exc = '0; intr = '0; haz = 1'b0; iret = 1'b1;
        repeat (8) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Parameters
REQ-001 SIG_W, default 41, width of the control word.
REQ-002 N_EXC, default 4, number of exception request lines; index 0 has the highest priority.
REQ-003 N_INT, default 3, number of interrupt request lines; index 0 has the highest priority.
REQ-004 FLUSH_CYC, default 2, number of NOP cycles (range 1..15) issued after each exception or interrupt entry word.
REQ-005 RST_WORD / BOOT_WORD / NOP_WORD, each SIG_W bits, are the control words for reset, the first post-reset cycle, and idle/flush.
REQ-006 EXC_WORDS (N_EXC×SIG_W) and INT_WORDS (N_INT×SIG_W) are the per-source entry words; source i occupies slice [i*SIG_W +: SIG_W].
REQ-007 HAZ_LSB, default 24, and HAZ_VAL, default 8'b0100_0111, define the 8-bit field overwritten during a control hazard.

Interface
REQ-008 clk  in  1  single clock; all state updates on its rising edge.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 dec_word  in  SIG_W  decoded control word for the current opcode.
REQ-011 ctrl_haz  in  1  control-hazard indication.
REQ-012 exceptions  in  N_EXC  exception request levels.
REQ-013 interrupts  in  N_INT  interrupt request pulses or levels.
REQ-014 int_ret  in  1  handler-return strobe; re-enables interrupts.
REQ-015 signals  out  SIG_W  registered control word.
REQ-016 state_o  out  3  current FSM state encoding.
REQ-017 int_busy  out  1  high while interrupts are masked.

Function
REQ-018 FSM states and encodings: BOOT=0, RUN=1, EXC=2, INT=3, FLUSH=4.
REQ-019 signals is a register with 1-cycle latency from inputs; no combinational path from any input to signals.
REQ-020 BOOT: asserted for exactly one cycle after reset release; signals=BOOT_WORD; next state RUN.
REQ-021 RUN: exception takes priority over interrupt, which takes priority over decode.
REQ-022 RUN: if any exceptions bit is set, latch the lowest set index e, load signals=EXC_WORDS[e], go to EXC.
REQ-023 RUN: else if (pend & ~int_busy) is nonzero, take the lowest set index i, load signals=INT_WORDS[i], clear pend[i], set int_busy, go to INT.
REQ-024 RUN: otherwise load signals=dec_word, with bits [HAZ_LSB+7:HAZ_LSB] replaced by HAZ_VAL when ctrl_haz=1.
REQ-025 Hazard override applies only in RUN; it is ignored in every other state.
REQ-026 EXC and INT: last exactly one cycle; next state FLUSH, with a flush counter loaded to FLUSH_CYC.
REQ-027 FLUSH: signals=NOP_WORD; counter decrements each cycle; exit to RUN on the cycle the counter reaches 1.
REQ-028 Exceptions arriving in FLUSH are ignored; exceptions are level-sensitive and must be held by the source.
REQ-029 pend[N_INT-1:0]: set by any cycle with interrupts[i]=1 in any state; held until serviced; setting and clearing the same bit in one cycle leaves it set.
REQ-030 int_ret=1 clears int_busy on the next edge; if int_ret coincides with interrupt entry, int_busy remains set.
REQ-031 Exception entry does not alter int_busy or pend.
REQ-032 state_o reflects the registered state.

Reset
REQ-033 While reset=0: signals=RST_WORD, state=BOOT, pend=0, int_busy=0, flush counter=0, asynchronously.
REQ-034 Reset asserted mid-EXC, INT, or FLUSH aborts the sequence immediately; no pending interrupt survives reset.

Verification
REQ-035 Reset release → one cycle BOOT_WORD, then dec_word passes through with 1-cycle latency (dec_word=0x0_0000_1A3 → signals=0x0_0000_1A3).
REQ-036 In RUN with ctrl_haz=1 and dec_word=0 → signals[31:24]=0x47, all other bits 0.
REQ-037 exceptions=4'b0110 in RUN → EXC_WORDS[1] for 1 cycle, NOP_WORD for 2 cycles, then RUN; interrupt asserted in the same cycle is deferred.
REQ-038 interrupts 3'b101 pulsed for one cycle → INT_WORDS[0] serviced; index 2 stays pending until int_ret, then INT_WORDS[2] issued.
REQ-039 reset asserted on the second FLUSH cycle → RST_WORD immediately, pend=0; after release, BOOT then RUN.
REQ-040 Parameter sweep SIG_W=64, N_EXC=8, N_INT=1, FLUSH_CYC=1 → same priority and timing behaviour.
